puzzle_board_engine: RTL and testbench

//  Parametrised sliding-puzzle board engine: loads one of NUM_LAYOUTS preset boards, then applies

---
 rtl/puzzle_pkg.sv | 36 +++
 rtl/puzzle_layout_rom.sv | 41 ++++
 rtl/puzzle_board_engine.sv | 174 +++++++++++++++++
 tb/tb_puzzle_board_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared definitions for the sliding-puzzle board engine: FSM states, blank
// move directions and the default 3x3 preset layout table.
package puzzle_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_IDLE  = 2'd2,
        ST_MOVE  = 2'd3
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int CELL_BLANK = 0;

    // Packed 3x3 layouts, cell 0 in the least significant nibble.
    localparam logic [35:0] LAY3X3_0 = 36'h087654321;
    localparam logic [35:0] LAY3X3_1 = 36'h807654321;
    localparam logic [35:0] LAY3X3_2 = 36'h857604321;
    localparam logic [35:0] LAY3X3_3 = 36'h876543210;

    function automatic int get_cell(input int layout, input int idx);
        logic [35:0] w_word;
        case (layout)
            1:       w_word = LAY3X3_1;
            2:       w_word = LAY3X3_2;
            3:       w_word = LAY3X3_3;
            default: w_word = LAY3X3_0;
        endcase
        return int'((w_word >> (4 * idx)) & 36'hF);
    endfunction

endpackage

// File: rtl/puzzle_layout_rom.sv
// Combinational preset-layout lookup: (layout, cell index) -> cell value.
// Non-3x3 boards use a solved board whose blank sits further left per layout.
module puzzle_layout_rom
    import puzzle_pkg::*;
#(
    parameter  int ROWS        = 3,
    parameter  int COLS        = 3,
    parameter  int CELL_W      = 4,
    parameter  int NUM_LAYOUTS = 4,
    localparam int N           = ROWS * COLS,
    localparam int LAY_W       = $clog2(NUM_LAYOUTS),
    localparam int IDX_W       = $clog2(N)
) (
    input  logic [LAY_W-1:0]  i_layout,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [CELL_W-1:0] o_cell
);

    int w_lay;
    int w_idx;
    int w_blank;
    int w_val;

    always_comb begin
        w_lay   = int'(i_layout);
        w_idx   = int'(i_idx);
        w_blank = N - 1 - (w_lay % N);
        if (N == 9) begin
            w_val = get_cell(w_lay, w_idx);
        end else if (w_idx < w_blank) begin
            w_val = w_idx + 1;
        end else if (w_idx == w_blank) begin
            w_val = CELL_BLANK;
        end else begin
            w_val = w_idx;
        end
    end

    assign o_cell = CELL_W'(w_val);

endmodule

// File: rtl/puzzle_board_engine.sv
// Sliding-puzzle board engine: loads a preset layout cell by cell, applies
// legality-checked blank moves, counts moves and flags the solved board.
module puzzle_board_engine
    import puzzle_pkg::*;
#(
    parameter  int ROWS        = 3,
    parameter  int COLS        = 3,
    parameter  int CELL_W      = 4,
    parameter  int NUM_LAYOUTS = 4,
    parameter  int CNT_W       = 10,
    localparam int N           = ROWS * COLS,
    localparam int LAY_W       = $clog2(NUM_LAYOUTS),
    localparam int IDX_W       = $clog2(N),
    localparam int BOARD_W     = N * CELL_W
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_new_valid,
    input  logic [LAY_W-1:0]   I_new,
    input  logic               I_move_valid,
    input  logic [1:0]         I_move_dir,
    output logic               O_ready,
    output logic [BOARD_W-1:0] O_board,
    output logic [IDX_W-1:0]   O_blank_idx,
    output logic [CNT_W-1:0]   O_move_cnt,
    output logic               O_move_ack,
    output logic               O_move_rej,
    output logic               O_solved
);

    state_t             r_state;
    logic [LAY_W-1:0]   r_layout;
    logic [IDX_W-1:0]   r_load_idx;
    logic [1:0]         r_dir;
    logic [CELL_W-1:0]  r_cells [N];
    logic [IDX_W-1:0]   r_blank;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_ack;
    logic               r_rej;
    logic               r_solved;

    logic [CELL_W-1:0]  w_rom_cell;
    logic [IDX_W-1:0]   w_row;
    logic [IDX_W-1:0]   w_col;
    logic [IDX_W-1:0]   w_nb;
    logic               w_legal;
    logic               w_solved;
    logic [LAY_W-1:0]   w_new_lay;

    puzzle_layout_rom #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .CELL_W      (CELL_W),
        .NUM_LAYOUTS (NUM_LAYOUTS)
    ) u_rom (
        .i_layout (r_layout),
        .i_idx    (r_load_idx),
        .o_cell   (w_rom_cell)
    );

    assign w_row     = r_blank / IDX_W'(COLS);
    assign w_col     = r_blank % IDX_W'(COLS);
    assign w_new_lay = (int'(I_new) < NUM_LAYOUTS) ? I_new : '0;

    // Legality is judged against the requested direction; the neighbour
    // index uses the direction latched when the move was accepted.
    always_comb begin
        case (I_move_dir)
            DIR_UP:   w_legal = (w_row != '0);
            DIR_DOWN: w_legal = (w_row != IDX_W'(ROWS - 1));
            DIR_LEFT: w_legal = (w_col != '0);
            default:  w_legal = (w_col != IDX_W'(COLS - 1));
        endcase
    end

    always_comb begin
        case (r_dir)
            DIR_UP:   w_nb = r_blank - IDX_W'(COLS);
            DIR_DOWN: w_nb = r_blank + IDX_W'(COLS);
            DIR_LEFT: w_nb = r_blank - IDX_W'(1);
            default:  w_nb = r_blank + IDX_W'(1);
        endcase
    end

    always_comb begin
        w_solved = (r_cells[N-1] == CELL_W'(CELL_BLANK));
        for (int i = 0; i < N - 1; i++) begin
            if (r_cells[i] != CELL_W'(i + 1)) begin
                w_solved = 1'b0;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        r_ack <= 1'b0;
        r_rej <= 1'b0;
        if (I_rst) begin
            r_state    <= ST_LOAD;
            r_layout   <= '0;
            r_load_idx <= '0;
            r_dir      <= DIR_UP;
            for (int i = 0; i < N; i++) begin
                r_cells[i] <= '0;
            end
            r_blank    <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_solved   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_cells[r_load_idx] <= w_rom_cell;
                    if (w_rom_cell == CELL_W'(CELL_BLANK)) begin
                        r_blank <= r_load_idx;
                    end
                    if (r_load_idx == IDX_W'(N - 1)) begin
                        r_load_idx <= '0;
                        r_state    <= ST_CHECK;
                    end else begin
                        r_load_idx <= r_load_idx + IDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    r_solved <= w_solved;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                ST_IDLE: begin
                    // A layout request takes priority and refuses any coincident move.
                    if (I_new_valid) begin
                        r_layout   <= w_new_lay;
                        r_load_idx <= '0;
                        r_cnt      <= '0;
                        r_ready    <= 1'b0;
                        r_rej      <= I_move_valid;
                        r_state    <= ST_LOAD;
                    end else if (I_move_valid) begin
                        if (w_legal) begin
                            r_dir   <= I_move_dir;
                            r_ready <= 1'b0;
                            r_state <= ST_MOVE;
                        end else begin
                            r_rej <= 1'b1;
                        end
                    end
                end
                ST_MOVE: begin
                    r_cells[r_blank] <= r_cells[w_nb];
                    r_cells[w_nb]    <= CELL_W'(CELL_BLANK);
                    r_blank          <= w_nb;
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    r_ack   <= 1'b1;
                    r_state <= ST_CHECK;
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_board
        assign O_board[g*CELL_W +: CELL_W] = r_cells[g];
    end

    assign O_ready     = r_ready;
    assign O_blank_idx = r_blank;
    assign O_move_cnt  = r_cnt;
    assign O_move_ack  = r_ack;
    assign O_move_rej  = r_rej;
    assign O_solved    = r_solved;

endmodule

// File: tb/tb_puzzle_board_engine.sv
// Bench for puzzle_board_engine: two 3x3 instances (CNT_W 10 and 2) share the
// same stimulus and are compared every cycle against a behavioural board model.
module tb_puzzle_board_engine;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst, new_v, mv_v;
    logic [1:0]  new_l, dir;

    logic        ready_a, ack_a, rej_a, solved_a;
    logic [35:0] board_a;
    logic [3:0]  blank_a;
    logic [9:0]  cnt_a;

    logic        ready_b, ack_b, rej_b, solved_b;
    logic [35:0] board_b;
    logic [3:0]  blank_b;
    logic [1:0]  cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    puzzle_board_engine dut_a (
        .I_clk(clk), .I_rst(rst), .I_new_valid(new_v), .I_new(new_l),
        .I_move_valid(mv_v), .I_move_dir(dir),
        .O_ready(ready_a), .O_board(board_a), .O_blank_idx(blank_a),
        .O_move_cnt(cnt_a), .O_move_ack(ack_a), .O_move_rej(rej_a), .O_solved(solved_a)
    );

    puzzle_board_engine #(.CNT_W(2)) dut_b (
        .I_clk(clk), .I_rst(rst), .I_new_valid(new_v), .I_new(new_l),
        .I_move_valid(mv_v), .I_move_dir(dir),
        .O_ready(ready_b), .O_board(board_b), .O_blank_idx(blank_b),
        .O_move_cnt(cnt_b), .O_move_ack(ack_b), .O_move_rej(rej_b), .O_solved(solved_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lay_cell(input int l, input int i);
        int t [N];
        case (l)
            1:       t = '{1, 2, 3, 4, 5, 6, 7, 0, 8};
            2:       t = '{1, 2, 3, 4, 0, 6, 7, 5, 8};
            3:       t = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
            default: t = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
        endcase
        return t[i];
    endfunction

    // ---------------- behavioural model ----------------
    int  m_board [N];
    int  m_blank, m_cnt, m_lay, m_pos, m_dir;
    bit  m_ready, m_ack, m_rej, m_solved, m_move_pend, m_check_pend;

    logic       s_rst, s_new_v, s_mv_v;
    logic [1:0] s_new_l, s_dir;
    bit         started = 0;

    always @(posedge clk) begin
        s_rst   <= rst;
        s_new_v <= new_v;
        s_new_l <= new_l;
        s_mv_v  <= mv_v;
        s_dir   <= dir;
        started <= 1'b1;
    end

    function automatic bit board_solved();
        for (int i = 0; i < N - 1; i++)
            if (m_board[i] != i + 1) return 0;
        return m_board[N-1] == 0;
    endfunction

    function automatic bit legal(input int b, input int d);
        int row = b / 3;
        int col = b % 3;
        case (d)
            0: return row > 0;
            1: return row < 2;
            2: return col > 0;
            default: return col < 2;
        endcase
    endfunction

    task automatic model_step();
        int v, nb;
        m_ack = 0;
        m_rej = 0;
        if (s_rst) begin
            for (int i = 0; i < N; i++) m_board[i] = 0;
            m_blank = 0; m_cnt = 0; m_ready = 0; m_solved = 0;
            m_lay = 0; m_pos = 0; m_move_pend = 0; m_check_pend = 0;
        end else if (m_pos >= 0) begin
            v = lay_cell(m_lay, m_pos);
            m_board[m_pos] = v;
            if (v == 0) m_blank = m_pos;
            m_pos++;
            if (m_pos == N) begin
                m_pos = -1;
                m_check_pend = 1;
            end
        end else if (m_check_pend) begin
            m_solved = board_solved();
            m_ready = 1;
            m_check_pend = 0;
        end else if (m_move_pend) begin
            case (m_dir)
                0: nb = m_blank - 3;
                1: nb = m_blank + 3;
                2: nb = m_blank - 1;
                default: nb = m_blank + 1;
            endcase
            m_board[m_blank] = m_board[nb];
            m_board[nb] = 0;
            m_blank = nb;
            m_cnt++;
            m_ack = 1;
            m_move_pend = 0;
            m_check_pend = 1;
        end else if (m_ready) begin
            if (s_new_v) begin
                m_lay = int'(s_new_l);
                m_pos = 0;
                m_cnt = 0;
                m_ready = 0;
                m_rej = s_mv_v;
            end else if (s_mv_v) begin
                if (legal(m_blank, int'(s_dir))) begin
                    m_dir = int'(s_dir);
                    m_move_pend = 1;
                    m_ready = 0;
                end else begin
                    m_rej = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [35:0] eb;
        if (started) begin
            model_step();
            for (int i = 0; i < N; i++) eb[i*4 +: 4] = 4'(m_board[i]);
            check("ready_a",  64'(ready_a),  64'(m_ready));
            check("ack_a",    64'(ack_a),    64'(m_ack));
            check("rej_a",    64'(rej_a),    64'(m_rej));
            check("board_a",  64'(board_a),  64'(eb));
            check("blank_a",  64'(blank_a),  64'(m_blank));
            check("cnt_a",    64'(cnt_a),    64'((m_cnt > 1023) ? 1023 : m_cnt));
            check("ready_b",  64'(ready_b),  64'(m_ready));
            check("ack_b",    64'(ack_b),    64'(m_ack));
            check("rej_b",    64'(rej_b),    64'(m_rej));
            check("board_b",  64'(board_b),  64'(eb));
            check("blank_b",  64'(blank_b),  64'(m_blank));
            check("cnt_b",    64'(cnt_b),    64'((m_cnt > 3) ? 3 : m_cnt));
            if (m_ready) begin
                check("solved_a", 64'(solved_a), 64'(m_solved));
                check("solved_b", 64'(solved_b), 64'(m_solved));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_move(input logic [1:0] d);
        mv_v = 1'b1;
        dir  = d;
        @(negedge clk);
        mv_v = 1'b0;
    endtask

    task automatic pulse_new(input logic [1:0] l, input logic with_move, input logic [1:0] d);
        new_v = 1'b1;
        new_l = l;
        mv_v  = with_move;
        dir   = d;
        @(negedge clk);
        new_v = 1'b0;
        mv_v  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; new_v = 1'b0; mv_v = 1'b0; new_l = '0; dir = '0;
        @(negedge clk);
        check("lit_rst_board", 64'(board_a), 64'h0);
        check("lit_rst_ready", 64'(ready_a), 64'h0);
        check("lit_rst_blank", 64'(blank_a), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        repeat (9) @(negedge clk);
        check("lit_load_busy", 64'(ready_a), 64'h0);
        @(negedge clk);
        check("lit_ready",   64'(ready_a),  64'h1);
        check("lit_board0",  64'(board_a),  64'h087654321);
        check("lit_blank0",  64'(blank_a),  64'd8);
        check("lit_solved0", 64'(solved_a), 64'h1);
        check("lit_cnt0",    64'(cnt_a),    64'h0);

        pulse_move(2'b01);
        check("lit_rej_down", 64'(rej_a), 64'h1);
        pulse_move(2'b11);
        check("lit_rej_right", 64'(rej_a),   64'h1);
        check("lit_rej_board", 64'(board_a), 64'h087654321);
        check("lit_rej_cnt",   64'(cnt_a),   64'h0);
        check("lit_rej_ready", 64'(ready_a), 64'h1);

        pulse_new(2'd1, 1'b0, 2'b00);
        repeat (9) @(negedge clk);
        check("lit_l1_busy",   64'(ready_a),  64'h0);
        @(negedge clk);
        check("lit_l1_ready",  64'(ready_a),  64'h1);
        check("lit_l1_board",  64'(board_a),  64'h807654321);
        check("lit_l1_blank",  64'(blank_a),  64'd7);
        check("lit_l1_solved", 64'(solved_a), 64'h0);

        pulse_move(2'b11);
        check("lit_mv_busy", 64'(ready_a), 64'h0);
        @(negedge clk);
        check("lit_mv_ack",   64'(ack_a),   64'h1);
        check("lit_mv_blank", 64'(blank_a), 64'd8);
        check("lit_mv_cnt",   64'(cnt_a),   64'h1);
        @(negedge clk);
        check("lit_mv_ready",  64'(ready_a),  64'h1);
        check("lit_mv_solved", 64'(solved_a), 64'h1);

        pulse_new(2'd1, 1'b1, 2'b00);
        check("lit_both_rej", 64'(rej_a), 64'h1);
        repeat (10) @(negedge clk);
        check("lit_both_blank", 64'(blank_a), 64'd7);
        check("lit_both_cnt",   64'(cnt_a),   64'h0);

        for (int k = 0; k < 5; k++) begin
            pulse_move((k % 2 == 0) ? 2'b00 : 2'b01);
            repeat (2) @(negedge clk);
        end
        check("lit_sat_b",   64'(cnt_b), 64'd3);
        check("lit_sat_a",   64'(cnt_a), 64'd5);
        check("lit_sat_blk", 64'(blank_a), 64'd4);

        pulse_new(2'd2, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("lit_midrst_board", 64'(board_a), 64'h0);
        check("lit_midrst_cnt",   64'(cnt_a),   64'h0);
        repeat (10) @(negedge clk);
        check("lit_reload_ready", 64'(ready_a),  64'h1);
        check("lit_reload_board", 64'(board_a),  64'h087654321);
        check("lit_reload_blank", 64'(blank_a),  64'd8);
        check("lit_reload_solv",  64'(solved_a), 64'h1);

        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 399) == 0);
            new_v = ($urandom_range(0, 29) == 0);
            new_l = 2'($urandom);
            mv_v  = ($urandom_range(0, 2) == 0);
            dir   = 2'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; new_v = 1'b0; mv_v = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
